// File: rtl/gb_mem_pkg.sv
// ---------------------------------------------------------------------------
// gb_mem_pkg
// Shared memory-map constants and the OAM DMA state type. The MMU and the
// DMA controller both import this package. The MMU uses DMA_IDLE_ADDR to
// recognise "no DMA transfer in progress" on the DMA bus-master port.
// No ports (package).
// ---------------------------------------------------------------------------
package gb_mem_pkg;

    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
    localparam logic [15:0] DMA_IDLE_ADDR = 16'hFFFF;
    localparam int          OAM_LEN       = 160;

    typedef enum logic [2:0] {
        IDLE,
        START,
        READ,
        WRITE,
        GAP
    } dma_state_t;

    // Pages 0xE0 and above are echo RAM (and OAM/IO for 0xFE/0xFF). These
    // fold back down by 0x20, so the engine always reads from WRAM there.
    function automatic logic [7:0] echoFold(input logic [7:0] v);
        return (v >= 8'hE0) ? (v - 8'h20) : v;
    endfunction

endpackage

// File: rtl/mem_if.sv
// ---------------------------------------------------------------------------
// mem_if
// Simple byte-wide memory port used between the MMU and its clients.
//   addr_select[15:0]  address driven by the master
//   write_value[7:0]   write data driven by the master
//   write_enable       write strobe driven by the master
//   read_out[7:0]      read data returned by the slave
// ---------------------------------------------------------------------------
interface mem_if;

    logic [15:0] addr_select;
    logic [7:0]  write_value;
    logic        write_enable;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_value,
        output write_enable,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_value,
        input  write_enable,
        output read_out
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// OAM DMA engine behind register 0xFF46. A CPU write of XX starts a copy of
// XX00-XX9F into OAM (FE00-FE9F), one byte every PERIOD clocks after a
// START_DELAY lead-in. While idle the DMA address is parked at 0xFFFF.
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   mmio_dma_if  register port from the MMU (0xFF46 read/write)
//   dma_req      bus-master port into the MMU
//   dma_active   high from trigger until the transfer finishes
//   dma_done     one-clock pulse when the transfer completes
// ---------------------------------------------------------------------------
module oam_dma_ctrl
    import gb_mem_pkg::*;
#(
    parameter int READ_LAT    = 2,
    parameter int PERIOD      = 4,
    parameter int START_DELAY = 4
) (
    input  logic  clk,
    input  logic  rst,
    mem_if.slave  mmio_dma_if,
    mem_if.master dma_req,
    output logic  dma_active,
    output logic  dma_done
);

    localparam int         GAP_LEN    = PERIOD - READ_LAT - 1;
    localparam logic [7:0] START_LAST = 8'(START_DELAY - 1);
    localparam logic [7:0] READ_LAST  = 8'(READ_LAT - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_LEN - 1);
    localparam logic [7:0] IDX_LAST   = 8'(OAM_LEN - 1);

    dma_state_t  r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_idx;
    logic [7:0]  r_srcHi;
    logic [7:0]  r_dmaReg;
    logic        r_hitPrev;
    logic [15:0] r_addr;
    logic [7:0]  r_dataLat;
    logic        r_we;
    logic        r_active;
    logic        r_done;

    dma_state_t  w_nextState;
    logic [7:0]  w_nextCnt;
    logic [7:0]  w_nextIdx;
    logic [7:0]  w_nextSrcHi;
    logic [15:0] w_nextAddr;
    logic        w_nextWe;
    logic        w_hit;
    logic        w_trig;
    logic        w_capture;
    logic        w_finish;

    assign dma_req.addr_select  = r_addr;
    assign dma_req.write_value  = r_dataLat;
    assign dma_req.write_enable = r_we;
    assign dma_active           = r_active;
    assign dma_done             = r_done;

    // Register readback is the only combinational output.
    always_comb begin
        mmio_dma_if.read_out = 8'hFF;
        if (mmio_dma_if.addr_select == DMA_REG_ADDR) begin
            mmio_dma_if.read_out = r_dmaReg;
        end
    end

    // A held write only triggers once: we look for the rising edge of the
    // register hit, not the level.
    always_comb begin
        w_hit  = mmio_dma_if.write_enable && (mmio_dma_if.addr_select == DMA_REG_ADDR);
        w_trig = w_hit && !r_hitPrev;
    end

    // Next-state logic. A trigger wins over everything, including the final
    // write, so a restart never produces a done pulse for the aborted copy.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_nextSrcHi = r_srcHi;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        if (w_trig) begin
            w_nextState = START;
            w_nextCnt   = 8'd0;
            w_nextIdx   = 8'd0;
            w_nextSrcHi = echoFold(mmio_dma_if.write_value);
        end else begin
            case (r_state)
                IDLE: begin
                    w_nextState = IDLE;
                end
                START: begin
                    if (r_cnt == START_LAST) begin
                        w_nextState = READ;
                        w_nextCnt   = 8'd0;
                    end else begin
                        w_nextCnt = r_cnt + 8'd1;
                    end
                end
                READ: begin
                    if (r_cnt == READ_LAST) begin
                        w_nextState = WRITE;
                        w_nextCnt   = 8'd0;
                        w_capture   = 1'b1;
                    end else begin
                        w_nextCnt = r_cnt + 8'd1;
                    end
                end
                WRITE: begin
                    w_nextCnt = 8'd0;
                    if (GAP_LEN > 0) begin
                        w_nextState = GAP;
                    end else if (r_idx == IDX_LAST) begin
                        w_nextState = IDLE;
                        w_finish    = 1'b1;
                    end else begin
                        w_nextState = READ;
                        w_nextIdx   = r_idx + 8'd1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_nextCnt = 8'd0;
                        if (r_idx == IDX_LAST) begin
                            w_nextState = IDLE;
                            w_finish    = 1'b1;
                        end else begin
                            w_nextState = READ;
                            w_nextIdx   = r_idx + 8'd1;
                        end
                    end else begin
                        w_nextCnt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Bus outputs are decoded from the next state so that they are registered
    // alongside the state itself and line up with it cycle for cycle.
    always_comb begin
        w_nextAddr = DMA_IDLE_ADDR;
        w_nextWe   = 1'b0;
        case (w_nextState)
            READ: begin
                w_nextAddr = {w_nextSrcHi, w_nextIdx};
            end
            WRITE: begin
                w_nextAddr = OAM_BASE + {8'h00, w_nextIdx};
                w_nextWe   = 1'b1;
            end
            default: begin
                w_nextAddr = DMA_IDLE_ADDR;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_idx     <= 8'd0;
            r_srcHi   <= 8'd0;
            r_dmaReg  <= 8'h00;
            r_hitPrev <= 1'b0;
            r_addr    <= DMA_IDLE_ADDR;
            r_dataLat <= 8'h00;
            r_we      <= 1'b0;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_idx     <= w_nextIdx;
            r_srcHi   <= w_nextSrcHi;
            r_hitPrev <= w_hit;
            r_addr    <= w_nextAddr;
            r_we      <= w_nextWe;
            r_active  <= (w_nextState != IDLE);
            r_done    <= w_finish;
            if (w_trig) begin
                r_dmaReg <= mmio_dma_if.write_value;
            end
            if (w_capture) begin
                r_dataLat <= dma_req.read_out;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_ctrl
// Directed bench for oam_dma_ctrl. A 64K memory model with one clock of read
// latency sits on the DMA port; every written OAM byte is captured and
// compared against a hand-defined source pattern.
// ---------------------------------------------------------------------------
module tb_oam_dma_ctrl;

    logic clk;
    logic rst;
    logic dmaActive;
    logic dmaDone;

    mem_if mmioBus ();
    mem_if dmaBus ();

    oam_dma_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .mmio_dma_if (mmioBus),
        .dma_req     (dmaBus),
        .dma_active  (dmaActive),
        .dma_done    (dmaDone)
    );

    logic [7:0] mem [0:65535];
    logic [7:0] oam [0:255];

    int checks;
    int errors;
    int cyc;
    int writes;
    int readsSeen;
    int badOrder;
    int badIdle;
    int badSrc;
    int doneCount;
    int doneCyc;
    int firstReadCyc;
    int firstWriteCyc;
    logic [15:0] lastWAddr;
    logic [7:0]  expSrcHi;

    // Source pattern: page C1 gives i^0x5A, every other page is offset so
    // that reading from the wrong page shows up in the OAM contents.
    function automatic logic [7:0] pat(input logic [7:0] hi, input logic [7:0] lo);
        return (lo ^ 8'h5A) + (hi - 8'hC1);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with one clock of read latency.
    always @(posedge clk) begin
        dmaBus.read_out <= mem[dmaBus.addr_select];
    end

    // Bus monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (dmaBus.write_enable) begin
            if (writes == 0) firstWriteCyc = cyc;
            if (dmaBus.addr_select[15:8] != 8'hFE || dmaBus.addr_select[7:0] > 8'd159 ||
                (writes > 0 && dmaBus.addr_select <= lastWAddr)) begin
                badOrder = badOrder + 1;
            end
            oam[dmaBus.addr_select[7:0]] = dmaBus.write_value;
            lastWAddr = dmaBus.addr_select;
            writes = writes + 1;
        end else if (dmaBus.addr_select != 16'hFFFF) begin
            if (readsSeen == 0) firstReadCyc = cyc;
            if (dmaBus.addr_select[15:8] != expSrcHi || dmaBus.addr_select[7:0] > 8'd159) begin
                badSrc = badSrc + 1;
            end
            readsSeen = readsSeen + 1;
        end
        if (!dmaActive && dmaBus.addr_select != 16'hFFFF) badIdle = badIdle + 1;
        if (dmaDone) begin
            if (doneCount == 0) doneCyc = cyc;
            doneCount = doneCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearMon(input logic [7:0] srcHi);
        writes        = 0;
        readsSeen     = 0;
        badOrder      = 0;
        badIdle       = 0;
        badSrc        = 0;
        doneCount     = 0;
        doneCyc       = -1;
        firstReadCyc  = -1;
        firstWriteCyc = -1;
        lastWAddr     = 16'h0000;
        expSrcHi      = srcHi;
    endtask

    // Write a value to 0xFF46 and hold the strobe for holdClocks edges.
    // cyc is zeroed right after the edge that samples the trigger.
    task automatic applyStimulus(input logic [7:0] value, input int holdClocks);
        @(negedge clk);
        mmioBus.addr_select  = 16'hFF46;
        mmioBus.write_value  = value;
        mmioBus.write_enable = 1'b1;
        @(negedge clk);
        cyc = 0;
        for (int i = 1; i < holdClocks; i++) @(negedge clk);
        mmioBus.write_enable = 1'b0;
        mmioBus.addr_select  = 16'h0000;
    endtask

    task automatic waitDone(input int maxCyc, input string tag);
        int n;
        n = 0;
        while (doneCount == 0 && n < maxCyc) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput(tag, (doneCount != 0), 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic waitWrites(input int target, input int maxCyc, input string tag);
        int n;
        n = 0;
        while (writes < target && n < maxCyc) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput(tag, writes, target);
    endtask

    task automatic checkOam(input logic [7:0] hi, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            if (oam[i] !== pat(hi, 8'(i))) bad = bad + 1;
        end
        checkOutput(tag, bad, 0);
    endtask

    task automatic readReg(input logic [15:0] addr, output logic [7:0] val);
        @(negedge clk);
        mmioBus.addr_select = addr;
        #1;
        val = mmioBus.read_out;
        mmioBus.addr_select = 16'h0000;
    endtask

    initial begin
        logic [7:0] rd;
        checks = 0;
        errors = 0;
        cyc    = 0;
        clearMon(8'hC1);
        for (int a = 0; a < 65536; a++) mem[a] = pat(8'(a >> 8), 8'(a));
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        mmioBus.addr_select  = 16'h0000;
        mmioBus.write_value  = 8'h00;
        mmioBus.write_enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        checkOutput("rstAddr", dmaBus.addr_select, 16'hFFFF);
        checkOutput("rstWe", dmaBus.write_enable, 1'b0);
        checkOutput("rstWv", dmaBus.write_value, 8'h00);
        checkOutput("rstActive", dmaActive, 1'b0);
        checkOutput("rstDone", dmaDone, 1'b0);
        readReg(16'hFF46, rd);
        checkOutput("rstReg", rd, 8'h00);
        readReg(16'hFF45, rd);
        checkOutput("otherAddrRead", rd, 8'hFF);

        // Basic transfer from page C1 and bus-shape checks
        $display("[TB] transfer from page C1");
        clearMon(8'hC1);
        applyStimulus(8'hC1, 1);
        checkOutput("activeAfterTrig", dmaActive, 1'b1);
        waitDone(800, "c1DoneSeen");
        checkOam(8'hC1, "c1OamData");
        checkOutput("c1DoneCyc", doneCyc, 644);
        checkOutput("c1DoneCount", doneCount, 1);
        checkOutput("c1Writes", writes, 160);
        checkOutput("c1Reads", readsSeen, 320);
        checkOutput("c1WriteOrder", badOrder, 0);
        checkOutput("c1IdleAddr", badIdle, 0);
        checkOutput("c1SrcPage", badSrc, 0);
        checkOutput("c1FirstRead", firstReadCyc, 4);
        checkOutput("c1FirstWrite", firstWriteCyc, 6);
        checkOutput("c1ActiveEnd", dmaActive, 1'b0);
        checkOutput("c1AddrEnd", dmaBus.addr_select, 16'hFFFF);

        // Restart mid-transfer: C1 then C2 at idx 50
        $display("[TB] restart C1 -> C2");
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        clearMon(8'hC1);
        applyStimulus(8'hC1, 1);
        waitWrites(50, 400, "rsWrites50");
        expSrcHi  = 8'hC2;
        lastWAddr = 16'h0000;
        writes    = 0;
        applyStimulus(8'hC2, 1);
        checkOutput("rsActiveKept", dmaActive, 1'b1);
        waitDone(800, "rsDoneSeen");
        checkOam(8'hC2, "rsOamData");
        checkOutput("rsDoneCount", doneCount, 1);
        checkOutput("rsWrites", writes, 160);
        checkOutput("rsSrcPage", badSrc, 0);
        readReg(16'hFF46, rd);
        checkOutput("rsReg", rd, 8'hC2);

        // Echo fold: F3 reads from D3
        $display("[TB] echo page F3");
        clearMon(8'hD3);
        applyStimulus(8'hF3, 1);
        waitDone(800, "f3DoneSeen");
        checkOam(8'hD3, "f3OamData");
        checkOutput("f3SrcPage", badSrc, 0);
        checkOutput("f3Reads", readsSeen, 320);
        readReg(16'hFF46, rd);
        checkOutput("f3Reg", rd, 8'hF3);

        // Reset mid-transfer at idx 80
        $display("[TB] reset mid-transfer");
        clearMon(8'hC1);
        applyStimulus(8'hC1, 1);
        waitWrites(80, 500, "rstMidWrites80");
        rst = 1'b1;
        @(negedge clk);
        mmioBus.addr_select = 16'hFF46;
        #1;
        checkOutput("rstMidAddr", dmaBus.addr_select, 16'hFFFF);
        checkOutput("rstMidWe", dmaBus.write_enable, 1'b0);
        checkOutput("rstMidActive", dmaActive, 1'b0);
        checkOutput("rstMidReg", mmioBus.read_out, 8'h00);
        rst = 1'b0;
        mmioBus.addr_select = 16'h0000;
        repeat (700) @(negedge clk);
        checkOutput("rstMidNoWrites", writes, 80);
        checkOutput("rstMidNoDone", doneCount, 0);

        // Held write counts as a single trigger
        $display("[TB] held write");
        clearMon(8'hC2);
        applyStimulus(8'hC2, 5);
        waitDone(800, "holdDoneSeen");
        checkOutput("holdDoneCyc", doneCyc, 644);
        checkOutput("holdDoneCount", doneCount, 1);
        checkOutput("holdWrites", writes, 160);
        checkOam(8'hC2, "holdOamData");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
